// File: rtl/sdrc_req_split_pkg.sv
// Shared types and helpers for the SDRAM request splitter.
package sdrc_split_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    localparam int unsigned COL_W_DEFAULT = 8;
    localparam int unsigned PAGE_WORDS    = 2 ** COL_W_DEFAULT;

    // Unsigned minimum of three values; callers zero-extend narrower operands to 32 bits.
    function automatic logic [31:0] min3(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] c);
        logic [31:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/sdrc_req_split_if.sv
// Host-request and sub-request handshake bundle for sdrc_req_split.
interface sdrc_req_split_if #(
    parameter int ADDR_W = 26,
    parameter int LEN_W  = 7
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              req_wr;

    logic              sub_valid;
    logic              sub_ready;
    logic [ADDR_W-1:0] sub_addr;
    logic [LEN_W-1:0]  sub_len;
    logic              sub_wr;
    logic              sub_last;

    modport slave (
        input  req_valid, req_addr, req_len, req_wr, sub_ready,
        output req_ready, sub_valid, sub_addr, sub_len, sub_wr, sub_last
    );

    modport master (
        output req_valid, req_addr, req_len, req_wr, sub_ready,
        input  req_ready, sub_valid, sub_addr, sub_len, sub_wr, sub_last
    );
endinterface

// File: rtl/sdrc_req_split_chunk.sv
// Combinational chunk size: min(remaining beats, MAX_BURST, words left in the page).
import sdrc_split_pkg::*;

module sdrc_chunk_calc #(
    parameter int LEN_W     = 7,
    parameter int COL_W     = 8,
    parameter int MAX_BURST = 8
) (
    input  logic [COL_W-1:0] col_i,
    input  logic [LEN_W-1:0] rem_i,
    output logic [LEN_W-1:0] chunk_o,
    output logic             is_last_o
);

    localparam logic [COL_W:0] PAGE = {1'b1, {COL_W{1'b0}}};

    // One extra bit so column 0 yields a full page rather than zero.
    logic [COL_W:0] page_rem;

    assign page_rem  = PAGE - {1'b0, col_i};
    assign chunk_o   = LEN_W'(min3(32'(rem_i), 32'(MAX_BURST), 32'(page_rem)));
    assign is_last_o = (rem_i == chunk_o);

endmodule

// File: rtl/sdrc_req_split.sv
// Splits a host request into page-safe, burst-limited SDRAM sub-requests.
import sdrc_split_pkg::*;

module sdrc_req_split #(
    parameter int ADDR_W    = 26,
    parameter int LEN_W     = 7,
    parameter int COL_W     = 8,
    parameter int MAX_BURST = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    sdrc_req_split_if.slave bus,
    output logic           busy
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              wr_q, wr_d;
    logic              vld_q, vld_d;
    logic              last_q, last_d;
    logic [LEN_W-1:0]  chunk;
    logic              is_last;

    // Chunk is computed from next-state values so sub_len/sub_last can be registered.
    sdrc_chunk_calc #(
        .LEN_W     (LEN_W),
        .COL_W     (COL_W),
        .MAX_BURST (MAX_BURST)
    ) u_calc (
        .col_i     (addr_d[COL_W-1:0]),
        .rem_i     (rem_d),
        .chunk_o   (chunk),
        .is_last_o (is_last)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wr_d    = wr_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && (bus.req_len != '0)) begin
                    addr_d  = bus.req_addr;
                    rem_d   = bus.req_len;
                    wr_d    = bus.req_wr;
                    vld_d   = 1'b1;
                    state_d = SPLIT;
                end
            end
            SPLIT: begin
                if (vld_q && bus.sub_ready) begin
                    addr_d = addr_q + ADDR_W'(len_q);
                    rem_d  = rem_q - len_q;
                    if (last_q) begin
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        len_d  = vld_d ? chunk : '0;
        last_d = vld_d & is_last;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            wr_q    <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.sub_valid = vld_q;
    assign bus.sub_addr  = addr_q;
    assign bus.sub_len   = len_q;
    assign bus.sub_wr    = wr_q;
    assign bus.sub_last  = last_q;
    assign busy          = (state_q == SPLIT);

endmodule

// File: tb/tb_sdrc_req_split.sv
// Directed, table-driven bench for sdrc_req_split with hand-computed sub-request sequences.
module tb_sdrc_req_split;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    int   errors = 0;
    int   checks = 0;

    sdrc_req_split_if #(.ADDR_W(26), .LEN_W(7)) bus ();

    sdrc_req_split #(
        .ADDR_W    (26),
        .LEN_W     (7),
        .COL_W     (8),
        .MAX_BURST (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [25:0] addr;
        logic [6:0]  len;
        logic        wr;
        int          n;
        logic [25:0] ea [3];
        logic [6:0]  el [3];
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_sub(input string tag, input logic [25:0] ea, input logic [6:0] el,
                             input logic elast, input logic ewr);
        check({tag, "_valid"}, 32'(bus.sub_valid), 32'd1);
        check({tag, "_addr"},  32'(bus.sub_addr),  32'(ea));
        check({tag, "_len"},   32'(bus.sub_len),   32'(el));
        check({tag, "_last"},  32'(bus.sub_last),  32'(elast));
        check({tag, "_wr"},    32'(bus.sub_wr),    32'(ewr));
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready_wait"}, 32'(bus.req_ready), 32'd1);
    endtask

    // Presents one request for exactly one accepting edge, then drops req_valid.
    task automatic issue(input logic [25:0] a, input logic [6:0] l, input logic w);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_len   = l;
        bus.req_wr    = w;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.req_wr    = 1'b0;
        bus.sub_ready = 1'b1;

        vecs[0] = '{26'h00000FC, 7'd10, 1'b0, 2, '{26'h00000FC, 26'h0000100, 26'h0}, '{7'd4, 7'd6, 7'd0}};
        vecs[1] = '{26'h0000010, 7'd20, 1'b1, 3, '{26'h0000010, 26'h0000018, 26'h0000020}, '{7'd8, 7'd8, 7'd4}};
        vecs[2] = '{26'h3FFFFFE, 7'd4,  1'b0, 2, '{26'h3FFFFFE, 26'h0000000, 26'h0}, '{7'd2, 7'd2, 7'd0}};
        vecs[3] = '{26'h00000F8, 7'd8,  1'b1, 1, '{26'h00000F8, 26'h0, 26'h0}, '{7'd8, 7'd0, 7'd0}};
        vecs[4] = '{26'h00001FF, 7'd3,  1'b0, 2, '{26'h00001FF, 26'h0000200, 26'h0}, '{7'd1, 7'd2, 7'd0}};

        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_valid", 32'(bus.sub_valid), 32'd0);
        check("rst_addr",  32'(bus.sub_addr),  32'd0);
        check("rst_len",   32'(bus.sub_len),   32'd0);
        check("rst_last",  32'(bus.sub_last),  32'd0);
        check("rst_wr",    32'(bus.sub_wr),    32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        #11 reset_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < NV; v++) begin
            wait_ready($sformatf("v%0d", v));
            issue(vecs[v].addr, vecs[v].len, vecs[v].wr);
            for (int s = 0; s < vecs[v].n; s++) begin
                check_sub($sformatf("v%0d_s%0d", v, s), vecs[v].ea[s], vecs[v].el[s],
                          (s == vecs[v].n - 1), vecs[v].wr);
                check($sformatf("v%0d_s%0d_busy", v, s), 32'(busy), 32'd1);
                @(posedge clk); #1;
            end
            check($sformatf("v%0d_end_valid", v), 32'(bus.sub_valid), 32'd0);
            check($sformatf("v%0d_end_ready", v), 32'(bus.req_ready), 32'd1);
        end

        // Zero-length request is consumed without any sub-request.
        wait_ready("zero");
        issue(26'h0000123, 7'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("zero_c%0d_ready", c), 32'(bus.req_ready), 32'd1);
            check($sformatf("zero_c%0d_valid", c), 32'(bus.sub_valid), 32'd0);
            check($sformatf("zero_c%0d_busy", c),  32'(busy),          32'd0);
            @(posedge clk); #1;
        end

        // Backpressure: first sub held stable while sub_ready is low.
        wait_ready("bp");
        bus.sub_ready = 1'b0;
        issue(26'h0000000, 7'd9, 1'b0);
        for (int c = 0; c < 3; c++) begin
            check_sub($sformatf("bp_hold%0d", c), 26'h0000000, 7'd8, 1'b0, 1'b0);
            check($sformatf("bp_hold%0d_ready", c), 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.sub_ready = 1'b1;
        check_sub("bp_hold3", 26'h0000000, 7'd8, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_sub("bp_s1", 26'h0000008, 7'd1, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("bp_end_valid", 32'(bus.sub_valid), 32'd0);
        check("bp_end_ready", 32'(bus.req_ready), 32'd1);

        // Reset in the middle of a long split.
        wait_ready("mid");
        issue(26'h0000000, 7'd100, 1'b1);
        check_sub("mid_s0", 26'h0000000, 7'd8, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_sub("mid_s1", 26'h0000008, 7'd8, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_sub("mid_s2", 26'h0000010, 7'd8, 1'b0, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.sub_valid), 32'd0);
        check("mid_rst_addr",  32'(bus.sub_addr),  32'd0);
        check("mid_rst_len",   32'(bus.sub_len),   32'd0);
        check("mid_rst_last",  32'(bus.sub_last),  32'd0);
        check("mid_rst_wr",    32'(bus.sub_wr),    32'd0);
        check("mid_rst_busy",  32'(busy),          32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        #3 reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("mid_post%0d_valid", c), 32'(bus.sub_valid), 32'd0);
            check($sformatf("mid_post%0d_busy", c),  32'(busy),          32'd0);
            check($sformatf("mid_post%0d_ready", c), 32'(bus.req_ready), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
